// File: rtl/ps2_joy_pkg.sv
// Shared scancodes, button indices, decoder states and keymap lookup for the
// PS/2 keyboard-to-joypad mapper.
package ps2_joy_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_REL    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    // Keymap A (arrows are E0-prefixed)
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_LALT   = 8'h11;
    localparam logic [7:0] SC_TAB    = 8'h0D;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_Z      = 8'h1A;
    localparam logic [7:0] SC_X      = 8'h22;
    localparam logic [7:0] SC_C      = 8'h21;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    // Keymap B
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_F      = 8'h2B;
    localparam logic [7:0] SC_G      = 8'h34;
    localparam logic [7:0] SC_H      = 8'h33;
    localparam logic [7:0] SC_Q      = 8'h15;
    localparam logic [7:0] SC_R      = 8'h2D;
    localparam logic [7:0] SC_T      = 8'h2C;
    localparam logic [7:0] SC_Y      = 8'h35;
    localparam logic [7:0] SC_U      = 8'h3C;

    // Pad-select digits
    localparam logic [7:0] SC_1      = 8'h16;
    localparam logic [7:0] SC_2      = 8'h1E;
    localparam logic [7:0] SC_3      = 8'h26;
    localparam logic [7:0] SC_4      = 8'h25;

    localparam logic [3:0] BTN_RIGHT = 4'd0;
    localparam logic [3:0] BTN_LEFT  = 4'd1;
    localparam logic [3:0] BTN_DOWN  = 4'd2;
    localparam logic [3:0] BTN_UP    = 4'd3;
    localparam logic [3:0] BTN_4     = 4'd4;
    localparam logic [3:0] BTN_5     = 4'd5;
    localparam logic [3:0] BTN_6     = 4'd6;
    localparam logic [3:0] BTN_7     = 4'd7;
    localparam logic [3:0] BTN_8     = 4'd8;
    localparam logic [3:0] BTN_9     = 4'd9;
    localparam logic [3:0] BTN_10    = 4'd10;
    localparam logic [3:0] BTN_11    = 4'd11;

    localparam logic MAP_A = 1'b0;
    localparam logic MAP_B = 1'b1;

    typedef enum logic [2:0] {
        DEC_IDLE    = 3'd0,
        DEC_EXT     = 3'd1,
        DEC_REL     = 3'd2,
        DEC_EXT_REL = 3'd3,
        DEC_PAUSE   = 3'd4
    } dec_state_t;

    // Returns {hit, button index}; a code with the wrong E0 qualifier misses.
    function automatic logic [4:0] map_key(input logic [7:0] code,
                                           input logic ext,
                                           input logic map_sel);
        logic       hit;
        logic [3:0] idx;
        hit = 1'b0;
        idx = BTN_RIGHT;
        if (map_sel == MAP_A) begin
            case (code)
                SC_UP:    begin hit = ext;  idx = BTN_UP;    end
                SC_DOWN:  begin hit = ext;  idx = BTN_DOWN;  end
                SC_LEFT:  begin hit = ext;  idx = BTN_LEFT;  end
                SC_RIGHT: begin hit = ext;  idx = BTN_RIGHT; end
                SC_SPACE: begin hit = !ext; idx = BTN_4;     end
                SC_LALT:  begin hit = !ext; idx = BTN_5;     end
                SC_TAB:   begin hit = !ext; idx = BTN_6;     end
                SC_ESC:   begin hit = !ext; idx = BTN_7;     end
                SC_Z:     begin hit = !ext; idx = BTN_8;     end
                SC_X:     begin hit = !ext; idx = BTN_9;     end
                SC_C:     begin hit = !ext; idx = BTN_10;    end
                SC_ENTER: begin hit = !ext; idx = BTN_11;    end
                default:  hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_W:    begin hit = !ext; idx = BTN_UP;    end
                SC_S:    begin hit = !ext; idx = BTN_DOWN;  end
                SC_A:    begin hit = !ext; idx = BTN_LEFT;  end
                SC_D:    begin hit = !ext; idx = BTN_RIGHT; end
                SC_F:    begin hit = !ext; idx = BTN_4;     end
                SC_G:    begin hit = !ext; idx = BTN_5;     end
                SC_H:    begin hit = !ext; idx = BTN_6;     end
                SC_Q:    begin hit = !ext; idx = BTN_7;     end
                SC_R:    begin hit = !ext; idx = BTN_8;     end
                SC_T:    begin hit = !ext; idx = BTN_9;     end
                SC_Y:    begin hit = !ext; idx = BTN_10;    end
                SC_U:    begin hit = !ext; idx = BTN_11;    end
                default: hit = 1'b0;
            endcase
        end
        return {hit, idx};
    endfunction

endpackage

// File: rtl/ps2_joy_mapper_rx.sv
// PS/2 receive front end: synchroniser, clock glitch filter, 11-bit frame
// deserialiser with parity/start/stop checking and mid-frame timeout.
module ps2_rx_frame #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 16384
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);
    localparam int TCW = $clog2(TIMEOUT + 1);

    logic [1:0]            clk_sync;
    logic [1:0]            data_sync;
    logic [FILTER_LEN-1:0] filt;
    logic [3:0]            bit_cnt;
    logic [9:0]            shreg;
    logic [TCW-1:0]        idle_cnt;
    logic                  fall;
    logic                  data_bit;
    logic                  last_bit;
    logic                  frame_ok;
    logic                  timed_out;

    assign data_bit  = data_sync[1];
    assign fall      = filt[FILTER_LEN-1] && (filt[FILTER_LEN-2:0] == '0);
    assign last_bit  = (bit_cnt == 4'd10);
    // shreg holds start in [0], data in [8:1], parity in [9]; data_bit is the stop bit
    assign frame_ok  = !shreg[0] && data_bit && (^shreg[9:1]);
    assign timed_out = !fall && (bit_cnt != 4'd0) && (idle_cnt == TCW'(TIMEOUT - 1));

    assign rx_byte  = shreg[8:1];
    assign rx_valid = fall && last_bit && frame_ok;
    assign rx_err   = (fall && last_bit && !frame_ok) || timed_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            filt      <= '1;
            bit_cnt   <= '0;
            shreg     <= '0;
            idle_cnt  <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            filt      <= {filt[FILTER_LEN-2:0], clk_sync[1]};
            if (fall) begin
                idle_cnt <= '0;
                if (last_bit) begin
                    bit_cnt <= '0;
                end else begin
                    shreg   <= {data_bit, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt == 4'd0) begin
                idle_cnt <= '0;
            end else if (timed_out) begin
                bit_cnt  <= '0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TCW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_joy_mapper.sv
// PS/2 keyboard-to-joypad mapper: decodes E0/F0/E1 scancode sequences into key
// events and maps them onto NUM_PLAYERS pads in shared or split mode.
module ps2_joy_mapper
    import ps2_joy_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_BUTTONS = 8,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT     = 16384,
    localparam int JW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int TW = NUM_PLAYERS * NUM_BUTTONS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps2_kbd_clk,
    input  logic          ps2_kbd_data,
    input  logic          split_mode,
    output logic [TW-1:0] joystick,
    output logic [JW-1:0] joy_num,
    output logic          key_strobe,
    output logic [7:0]    key_code,
    output logic          key_ext,
    output logic          key_release,
    output logic          frame_err
);
    localparam logic [TW-1:0] PAD_ONES = TW'({NUM_BUTTONS{1'b1}});

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    ps2_rx_frame #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_kbd_clk),
        .ps2_data (ps2_kbd_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    dec_state_t state, state_n;
    logic [2:0] skip, skip_n;
    logic       emit;
    logic       emit_ext;
    logic       emit_rel;

    assign emit_ext = (state == DEC_EXT) || (state == DEC_EXT_REL);
    assign emit_rel = (state == DEC_REL) || (state == DEC_EXT_REL);

    always_comb begin
        state_n = state;
        skip_n  = skip;
        emit    = 1'b0;
        if (rx_valid) begin
            case (state)
                DEC_IDLE: begin
                    case (rx_byte)
                        SC_EXT:   state_n = DEC_EXT;
                        SC_REL:   state_n = DEC_REL;
                        SC_PAUSE: begin
                            state_n = DEC_PAUSE;
                            skip_n  = 3'd7;
                        end
                        SC_BAT, SC_ACK, SC_RESEND, SC_ECHO, SC_ERR0, SC_ERR1: ;
                        default:  emit = 1'b1;
                    endcase
                end
                DEC_EXT: begin
                    if (rx_byte == SC_REL) begin
                        state_n = DEC_EXT_REL;
                    end else if (rx_byte != SC_EXT) begin
                        emit    = 1'b1;
                        state_n = DEC_IDLE;
                    end
                end
                DEC_REL, DEC_EXT_REL: begin
                    emit    = 1'b1;
                    state_n = DEC_IDLE;
                end
                DEC_PAUSE: begin
                    skip_n = skip - 3'd1;
                    if (skip == 3'd1) state_n = DEC_IDLE;
                end
                default: state_n = DEC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= DEC_IDLE;
            skip        <= '0;
            key_strobe  <= 1'b0;
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state      <= state_n;
            skip       <= skip_n;
            key_strobe <= emit;
            frame_err  <= rx_err;
            if (emit) begin
                key_code    <= rx_byte;
                key_ext     <= emit_ext;
                key_release <= emit_rel;
            end
        end
    end

    // Pad update stage: acts on the registered event, one cycle after key_strobe
    logic          eff_split;
    logic          split_q;
    logic          mode_chg;
    logic [TW-1:0] joy_q, joy_n;
    logic [JW-1:0] num_q, num_n;
    logic [4:0]    res_a, res_b;
    logic          ok_a, ok_b;
    logic [TW-1:0] btn_a, btn_b, sel;
    logic          dig_hit;
    logic [1:0]    dig_idx;
    logic          dig_ok;
    int unsigned   shamt;

    assign eff_split = split_mode && (NUM_PLAYERS > 1);
    assign mode_chg  = (split_q != eff_split);
    assign res_a     = map_key(key_code, key_ext, MAP_A);
    assign res_b     = map_key(key_code, key_ext, MAP_B);
    assign ok_a      = res_a[4] && (32'(res_a[3:0]) < NUM_BUTTONS);
    assign ok_b      = res_b[4] && (32'(res_b[3:0]) < NUM_BUTTONS);
    assign btn_a     = ok_a ? (TW'(1) << res_a[3:0]) : '0;
    assign btn_b     = ok_b ? (TW'(1) << res_b[3:0]) : '0;
    assign shamt     = NUM_BUTTONS * 32'(num_q);

    always_comb begin
        dig_hit = 1'b1;
        dig_idx = 2'd0;
        case (key_code)
            SC_1:    dig_idx = 2'd0;
            SC_2:    dig_idx = 2'd1;
            SC_3:    dig_idx = 2'd2;
            SC_4:    dig_idx = 2'd3;
            default: dig_hit = 1'b0;
        endcase
    end

    assign dig_ok = !eff_split && dig_hit && !key_ext && !key_release
                    && (32'(dig_idx) < NUM_PLAYERS) && (JW'(dig_idx) != num_q);

    always_comb begin
        joy_n = joy_q;
        num_n = num_q;
        sel   = '0;
        if (mode_chg) begin
            joy_n = '0;
        end else if (key_strobe) begin
            if (eff_split) begin
                sel = btn_a | (btn_b << NUM_BUTTONS);
            end else if (dig_ok) begin
                joy_n = joy_q & ~(PAD_ONES << shamt);
                num_n = JW'(dig_idx);
            end else begin
                sel = btn_a << shamt;
            end
            joy_n = key_release ? (joy_n & ~sel) : (joy_n | sel);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            joy_q   <= '0;
            num_q   <= '0;
            split_q <= eff_split;
        end else begin
            joy_q   <= joy_n;
            num_q   <= num_n;
            split_q <= eff_split;
        end
    end

    assign joystick = joy_q;
    assign joy_num  = num_q;

endmodule

// File: tb/tb_ps2_joy_mapper.sv
// Scoreboard bench for ps2_joy_mapper (2 pads x 12 buttons): key sequences push
// expected events/pad states; a monitor pops and compares on each key_strobe.
module tb_ps2_joy_mapper;

    localparam int H       = 10;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        kclk = 1'b1;
    logic        kdat = 1'b1;
    logic        split_mode = 1'b0;
    logic [23:0] joystick;
    logic [0:0]  joy_num;
    logic        key_strobe;
    logic [7:0]  key_code;
    logic        key_ext;
    logic        key_release;
    logic        frame_err;

    always #5 clk = ~clk;

    ps2_joy_mapper #(
        .NUM_PLAYERS (2),
        .NUM_BUTTONS (12),
        .FILTER_LEN  (4),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_kbd_clk  (kclk),
        .ps2_kbd_data (kdat),
        .split_mode   (split_mode),
        .joystick     (joystick),
        .joy_num      (joy_num),
        .key_strobe   (key_strobe),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_release  (key_release),
        .frame_err    (frame_err)
    );

    int vectors = 0;
    int miscompares = 0;
    int strobes = 0;
    int pushed = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  code;
        logic        ext;
        logic        rel;
        logic [23:0] pre;
        logic [23:0] post;
        logic        num;
    } ev_t;
    ev_t sb[$];

    // Reference model state
    logic [23:0] m_joy = '0;
    logic        m_num = 1'b0;
    logic        m_split = 1'b0;

    localparam logic [95:0] KA = {8'h5A, 8'h21, 8'h22, 8'h1A, 8'h76, 8'h0D,
                                  8'h11, 8'h29, 8'h75, 8'h72, 8'h6B, 8'h74};
    localparam logic [95:0] KB = {8'h3C, 8'h35, 8'h2C, 8'h2D, 8'h15, 8'h33,
                                  8'h34, 8'h2B, 8'h1D, 8'h1B, 8'h1C, 8'h23};
    localparam logic [31:0] DIGS = {8'h25, 8'h26, 8'h1E, 8'h16};

    function automatic int find_key(input logic [7:0] c, input bit e, input bit mb);
        logic [95:0] t;
        t = mb ? KB : KA;
        for (int i = 0; i < 12; i++) begin
            if (t[7:0] == c && e == (!mb && i < 4)) return i;
            t = t >> 8;
        end
        return -1;
    endfunction

    function automatic int find_digit(input logic [7:0] c);
        logic [31:0] t;
        t = DIGS;
        for (int i = 0; i < 4; i++) begin
            if (t[7:0] == c) return i;
            t = t >> 8;
        end
        return -1;
    endfunction

    task automatic apply_bit(input int pos, input bit r);
        if (r) m_joy = m_joy & ~(24'd1 << pos);
        else   m_joy = m_joy | (24'd1 << pos);
    endtask

    task automatic model(input logic [7:0] c, input bit e, input bit r);
        int a, b, d;
        a = find_key(c, e, 1'b0);
        b = find_key(c, e, 1'b1);
        d = find_digit(c);
        if (m_split) begin
            if (a >= 0) apply_bit(a, r);
            if (b >= 0) apply_bit(12 + b, r);
        end else if (d >= 0 && d < 2 && !e && !r) begin
            if (d != int'(m_num)) begin
                m_joy = m_joy & ~(24'hFFF << (int'(m_num) * 12));
                m_num = (d == 1);
            end
        end else if (a >= 0) begin
            apply_bit(int'(m_num) * 12 + a, r);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit badp, input int nbits);
        logic [10:0] f;
        f = {1'b1, ~(^b) ^ badp, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            kdat = f[0];
            f = f >> 1;
            repeat (H) @(posedge clk);
            kclk = 1'b0;
            repeat (H) @(posedge clk);
            kclk = 1'b1;
        end
        repeat (H) @(posedge clk);
        kdat = 1'b1;
        repeat (2 * H) @(posedge clk);
    endtask

    task automatic key(input logic [7:0] c, input bit e, input bit r);
        ev_t ev;
        ev.code = c;
        ev.ext  = e;
        ev.rel  = r;
        ev.pre  = m_joy;
        model(c, e, r);
        ev.post = m_joy;
        ev.num  = m_num;
        sb.push_back(ev);
        pushed++;
        if (e) send(8'hE0, 1'b0, 11);
        if (r) send(8'hF0, 1'b0, 11);
        send(c, 1'b0, 11);
    endtask

    task automatic set_split(input bit s);
        split_mode = s;
        m_split = s;
        m_joy = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mode_clr", {40'd0, joystick}, {40'd0, m_joy});
    endtask

    always @(negedge clk) if (!reset && frame_err) errs++;

    always begin
        @(negedge clk);
        if (!reset && key_strobe) begin
            strobes++;
            if (sb.size() > 0) begin
                ev_t ev;
                ev = sb.pop_front();
                chk("code",    {56'd0, key_code},    {56'd0, ev.code});
                chk("ext",     {63'd0, key_ext},     {63'd0, ev.ext});
                chk("rel",     {63'd0, key_release}, {63'd0, ev.rel});
                chk("joy_pre", {40'd0, joystick},    {40'd0, ev.pre});
                @(negedge clk);
                chk("joy",     {40'd0, joystick},    {40'd0, ev.post});
                chk("joy_num", {63'd0, joy_num},     {63'd0, ev.num});
            end
        end
    end

    initial begin
        int s0, e0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset", {27'd0, joystick, joy_num, key_strobe, key_code, key_ext,
                      key_release, frame_err}, 64'd0);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        // Arrow up press/release on pad 0, then ext-mismatched codes
        key(8'h75, 1'b1, 1'b0);
        key(8'h75, 1'b1, 1'b1);
        key(8'h75, 1'b0, 1'b0);
        key(8'h11, 1'b1, 1'b0);
        key(8'h11, 1'b1, 1'b1);

        // Pad select: press space on pad 0, move to pad 1, illegal pad 3
        key(8'h29, 1'b0, 1'b0);
        key(8'h29, 1'b0, 1'b0);
        key(8'h1E, 1'b0, 1'b0);
        key(8'h26, 1'b0, 1'b0);
        key(8'h1E, 1'b0, 1'b0);
        key(8'h29, 1'b0, 1'b0);
        key(8'h0D, 1'b0, 1'b0);
        key(8'h29, 1'b0, 1'b1);
        key(8'h16, 1'b0, 1'b0);
        key(8'h5A, 1'b0, 1'b0);

        // Bad parity frame: error, no event
        s0 = strobes;
        e0 = errs;
        send(8'h29, 1'b1, 11);
        repeat (10) @(posedge clk);
        chk("par_err",      64'(errs),    64'(e0 + 1));
        chk("par_nostrobe", 64'(strobes), 64'(s0));

        // Truncated frame times out; the next frame decodes cleanly
        e0 = errs;
        send(8'h76, 1'b0, 5);
        repeat (TIMEOUT + 100) @(posedge clk);
        chk("tmo_err", 64'(errs), 64'(e0 + 1));
        key(8'h76, 1'b0, 1'b0);
        chk("tmo_noerr", 64'(errs), 64'(e0 + 1));

        // Ignored byte and pause sequence emit nothing; then one space event
        s0 = strobes;
        send(8'hAA, 1'b0, 11);
        send(8'hE1, 1'b0, 11);
        send(8'h14, 1'b0, 11);
        send(8'h77, 1'b0, 11);
        send(8'hE1, 1'b0, 11);
        send(8'hF0, 1'b0, 11);
        send(8'h14, 1'b0, 11);
        send(8'hF0, 1'b0, 11);
        send(8'h77, 1'b0, 11);
        chk("pause_quiet", 64'(strobes), 64'(s0));
        key(8'h29, 1'b0, 1'b0);
        chk("pause_one", 64'(strobes), 64'(s0 + 1));

        // Split mode: both pads at once, digits ignored, toggle clears
        set_split(1'b1);
        key(8'h74, 1'b1, 1'b0);
        key(8'h1D, 1'b0, 1'b0);
        chk("split_joy", {40'd0, joystick}, {40'd0, 24'h008_001});
        key(8'h16, 1'b0, 1'b0);
        key(8'h3C, 1'b0, 1'b0);
        key(8'h1D, 1'b0, 1'b1);
        set_split(1'b0);
        key(8'h6B, 1'b1, 1'b0);

        repeat (20) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("strobes",  64'(strobes),   64'(pushed));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
